// File: rtl/sw_cond_pkg.sv
// Shared types and constants for the board switch conditioner.
package sw_cond_pkg;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;
  localparam int unsigned OPERAND_W               = 32;
  localparam int unsigned SW_W                    = 16;
  localparam int unsigned BYTE_W                  = 8;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_e;

  // Per-byte inequality: bit1 = high byte differs, bit0 = low byte differs.
  function automatic logic [1:0] byte_diff(input logic [SW_W-1:0] a, input logic [SW_W-1:0] b);
    return {a[15:8] != b[15:8], a[7:0] != b[7:0]};
  endfunction
endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser for asynchronous inputs; no logic between stages.
module sync_chain #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/sw_input_conditioner.sv
// Synchronises and debounces the 16 board switches as one vector and publishes
// them atomically as two zero-extended operands with a one-cycle change strobe.
module sw_input_conditioner
  import sw_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 CLK10MHZ,
  input  logic                 CPU_RESETN,
  input  logic [SW_W-1:0]      SW,
  output logic [OPERAND_W-1:0] num1,
  output logic [OPERAND_W-1:0] num2,
  output logic [SW_W-1:0]      sw_stable,
  output logic                 changed,
  output logic [1:0]           chg_mask,
  output logic                 settling
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync_q;
  state_e           state_q, state_d;
  logic [SW_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW_W-1:0]  stable_q, stable_d;
  logic             changed_q, changed_d;
  logic [1:0]       mask_q, mask_d;

  sync_chain #(
    .WIDTH (SW_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK10MHZ),
    .rst_n (CPU_RESETN),
    .d     (SW),
    .q     (sync_q)
  );

  always_ff @(posedge CLK10MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q   <= STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      mask_q    <= mask_d;
    end
  end

  // Any movement of the synchronised vector restarts the settle window.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    mask_d    = '0;
    case (state_q)
      STABLE: begin
        if (sync_q != stable_q) begin
          cand_d  = sync_q;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end
      SETTLING: begin
        if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = cand_q;
          changed_d = (cand_q != stable_q);
          mask_d    = byte_diff(cand_q, stable_q);
          state_d   = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign sw_stable = stable_q;
  assign num1      = OPERAND_W'(stable_q[7:0]);
  assign num2      = OPERAND_W'(stable_q[15:8]);
  assign changed   = changed_q;
  assign chg_mask  = mask_q;
  assign settling  = (state_q == SETTLING);
endmodule

// File: tb/tb_sw_input_conditioner.sv
// Randomised and directed bench for sw_input_conditioner, two parameter sets
// driven by the same switch stimulus and checked against a sliding-window model.
module tb_sw_input_conditioner;
  localparam int unsigned S_A = 2;
  localparam int unsigned D_A = 4;
  localparam int unsigned S_B = 3;
  localparam int unsigned D_B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;

  logic [31:0] num1_o     [2];
  logic [31:0] num2_o     [2];
  logic [15:0] stable_o   [2];
  logic        changed_o  [2];
  logic [1:0]  mask_o     [2];
  logic        settling_o [2];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #50 clk = ~clk;

  sw_input_conditioner #(.SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A)) dut_a (
    .CLK10MHZ (clk), .CPU_RESETN (rst_n), .SW (sw),
    .num1 (num1_o[0]), .num2 (num2_o[0]), .sw_stable (stable_o[0]),
    .changed (changed_o[0]), .chg_mask (mask_o[0]), .settling (settling_o[0])
  );

  sw_input_conditioner #(.SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B)) dut_b (
    .CLK10MHZ (clk), .CPU_RESETN (rst_n), .SW (sw),
    .num1 (num1_o[1]), .num2 (num2_o[1]), .sw_stable (stable_o[1]),
    .changed (changed_o[1]), .chg_mask (mask_o[1]), .settling (settling_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a delay line for the synchroniser, then a commit whenever the
  // last D+1 observed samples since the vector first moved are identical.
  logic [15:0] m_pipe   [2][8];
  logic [15:0] m_hist   [2][8];
  int          m_hcnt   [2];
  logic [15:0] m_stable [2];
  logic        m_changed[2];
  logic [1:0]  m_mask   [2];
  logic        m_pend   [2];

  task automatic model_reset(input int i);
    for (int k = 0; k < 8; k++) begin
      m_pipe[i][k] = '0;
      m_hist[i][k] = '0;
    end
    m_hcnt[i]    = 0;
    m_stable[i]  = '0;
    m_changed[i] = 1'b0;
    m_mask[i]    = '0;
    m_pend[i]    = 1'b0;
  endtask

  task automatic model_step(input int i, input int s, input int d, input logic [15:0] in);
    logic [15:0] x;
    bit          all_eq;
    x = m_pipe[i][s-1];
    for (int k = s - 1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
    m_pipe[i][0] = in;
    m_changed[i] = 1'b0;
    m_mask[i]    = '0;
    if (!m_pend[i]) begin
      if (x != m_stable[i]) begin
        m_pend[i]    = 1'b1;
        m_hist[i][0] = x;
        m_hcnt[i]    = 1;
      end
    end else begin
      for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
      m_hist[i][0] = x;
      if (m_hcnt[i] < 8) m_hcnt[i]++;
      all_eq = (m_hcnt[i] >= d + 1);
      for (int k = 0; k <= d; k++) if (m_hist[i][k] != x) all_eq = 1'b0;
      if (all_eq) begin
        m_changed[i] = (x != m_stable[i]);
        m_mask[i]    = {x[15:8] != m_stable[i][15:8], x[7:0] != m_stable[i][7:0]};
        m_stable[i]  = x;
        m_pend[i]    = 1'b0;
      end
    end
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, S_A, D_A, sw);
      model_step(1, S_B, D_B, sw);
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc_stable%0d", i),   32'(stable_o[i]),   32'(m_stable[i]));
        check($sformatf("cyc_num1_%0d", i),    num1_o[i],          {24'h0, m_stable[i][7:0]});
        check($sformatf("cyc_num2_%0d", i),    num2_o[i],          {24'h0, m_stable[i][15:8]});
        check($sformatf("cyc_changed%0d", i),  32'(changed_o[i]),  32'(m_changed[i]));
        check($sformatf("cyc_mask%0d", i),     32'(mask_o[i]),     32'(m_mask[i]));
        check($sformatf("cyc_settling%0d", i), 32'(settling_o[i]), 32'(m_pend[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_num1_%0d", tag, i),    num1_o[i], 32'h0);
      check($sformatf("%s_num2_%0d", tag, i),    num2_o[i], 32'h0);
      check($sformatf("%s_stable%0d", tag, i),   32'(stable_o[i]), 32'h0);
      check($sformatf("%s_changed%0d", tag, i),  32'(changed_o[i]), 32'h0);
      check($sformatf("%s_mask%0d", tag, i),     32'(mask_o[i]), 32'h0);
      check($sformatf("%s_settling%0d", tag, i), 32'(settling_o[i]), 32'h0);
    end
  endtask

  initial begin
    bit saw_chg;
    bit saw_set;
    int r;
    rst_n = 1'b0;
    sw    = 16'h0000;
    repeat (3) tick();
    chk_en = 1'b1;
    check_all_zero("reset");

    // Quiet release: nothing may move.
    rst_n   = 1'b1;
    saw_chg = 1'b0;
    saw_set = 1'b0;
    repeat (20) begin
      tick();
      saw_chg |= changed_o[0] | changed_o[1];
      saw_set |= settling_o[0] | settling_o[1];
    end
    check("quiet_changed", 32'(saw_chg), 32'h0);
    check("quiet_settling", 32'(saw_set), 32'h0);
    check("quiet_num1", num1_o[0], 32'h0);

    // Step to 12AB before edge 1: B commits at edge 6, A at edge 7.
    rst_n = 1'b0;
    sw    = 16'h12AB;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("step_b_stable", 32'(stable_o[1]), 32'h12AB);
    check("step_b_changed", 32'(changed_o[1]), 32'h1);
    check("step_b_mask", 32'(mask_o[1]), 32'h3);
    check("step_a_early", 32'(stable_o[0]), 32'h0);
    tick();
    check("step_a_stable", 32'(stable_o[0]), 32'h12AB);
    check("step_a_num1", num1_o[0], 32'h000000AB);
    check("step_a_num2", num2_o[0], 32'h00000012);
    check("step_a_changed", 32'(changed_o[0]), 32'h1);
    check("step_a_mask", 32'(mask_o[0]), 32'h3);
    check("step_b_pulse_end", 32'(changed_o[1]), 32'h0);
    check("model_a_stable", 32'(m_stable[0]), 32'h12AB);
    tick();
    check("step_a_pulse_end", 32'(changed_o[0]), 32'h0);
    check("step_a_mask_end", 32'(mask_o[0]), 32'h0);

    // Bit0 chatter, then rest at 12AA: commit 7 edges after the last edge.
    repeat (3) tick();
    for (int t = 0; t < 6; t++) begin
      sw = (t % 2 == 0) ? 16'h12AA : 16'h12AB;
      tick();
    end
    sw = 16'h12AA;
    repeat (6) tick();
    check("chatter_hold", 32'(stable_o[0]), 32'h12AB);
    tick();
    check("chatter_stable", 32'(stable_o[0]), 32'h12AA);
    check("chatter_changed", 32'(changed_o[0]), 32'h1);
    check("chatter_mask", 32'(mask_o[0]), 32'h1);
    check("chatter_num1", num1_o[0], 32'h000000AA);

    // Two-cycle glitch on the high byte: settles back, no strobe.
    sw = 16'h12AB;
    repeat (12) tick();
    check("glitch_pre", 32'(stable_o[0]), 32'h12AB);
    sw = 16'h13AB;
    tick();
    tick();
    sw      = 16'h12AB;
    saw_chg = 1'b0;
    saw_set = 1'b0;
    repeat (14) begin
      tick();
      saw_chg |= changed_o[0] | changed_o[1];
      saw_set |= settling_o[0];
    end
    check("glitch_settling", 32'(saw_set), 32'h1);
    check("glitch_changed", 32'(saw_chg), 32'h0);
    check("glitch_stable_a", 32'(stable_o[0]), 32'h12AB);
    check("glitch_stable_b", 32'(stable_o[1]), 32'h12AB);

    // Reset mid-settle discards the candidate; re-commit after release.
    sw = 16'hFF00;
    repeat (5) tick();
    check("midsettle_settling", 32'(settling_o[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("rerel_early", 32'(stable_o[0]), 32'h0);
    tick();
    check("rerel_stable", 32'(stable_o[0]), 32'hFF00);
    check("rerel_changed", 32'(changed_o[0]), 32'h1);
    check("rerel_mask", 32'(mask_o[0]), 32'h2);
    check("rerel_num1", num1_o[0], 32'h0);
    check("rerel_num2", num2_o[0], 32'h000000FF);

    // Random switch activity with occasional resets.
    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 8) sw = 16'($urandom);
      else if (r < 18) sw = sw ^ (16'h1 << $urandom_range(0, 15));
      else if (r == 99 && $urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
